uart_rx_packet: RTL and testbench

//  Serial receiver for the router's 5-byte UART packet link; the inverse of the transmit side.

---
 rtl/uart_rx_packet_pkg.sv | 18 +
 rtl/uart_rx_packet_if.sv | 18 +
 rtl/uart_rx_byte.sv | 111 +++++++++++
 rtl/uart_rx_packet.sv | 82 ++++++++
 tb/tb_uart_rx_packet.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_packet_pkg.sv
// Shared definitions for the UART packet receiver: FSM encoding and defaults.
// Build option: UART_RX_PARITY_EN adds an even-parity bit after D7.
package uart_rx_packet_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_PKT_BYTES    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_packet_if.sv
// Serial line plus received-packet outputs of the UART packet receiver.
// master = line driver / packet consumer, slave = receiver.
interface uart_rx_packet_if;
  logic       uart_in;
  logic [7:0] byte0, byte1, byte2, byte3, byte4;
  logic       packet_valid;
  logic       frame_err;

  modport master (
    output uart_in,
    input  byte0, byte1, byte2, byte3, byte4, packet_valid, frame_err
  );

  modport slave (
    input  uart_in,
    output byte0, byte1, byte2, byte3, byte4, packet_valid, frame_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// Single-frame UART deserialiser: synchroniser, frame FSM and bit timing.
// Build option: UART_RX_PARITY_EN inserts the PARITY state between DATA and STOP.
// byte_strobe / byte_err are combinational in the mid-bit sample cycle of the frame end.
module uart_rx_byte
  import uart_rx_packet_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       byte_err,
  output logic       busy
);
  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state, state_nxt;
  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          err_wait;
  logic          fall, half_tick, full_tick;

  assign fall      = rx_d & ~rx_s;
  assign half_tick = (cnt == HALF_M1);
  assign full_tick = (cnt == FULL_M1);
  assign byte_data = shift;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; after a frame error STOP holds until the line returns high
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fall) state_nxt = ST_START;
      ST_START: if (half_tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (full_tick && bit_idx == 3'd7) state_nxt = ST_PARITY;
      ST_PARITY: if (full_tick) state_nxt = ST_STOP;
`else
      ST_DATA:   if (full_tick && bit_idx == 3'd7) state_nxt = ST_STOP;
`endif
      ST_STOP: begin
        if (err_wait) begin
          if (rx_s) state_nxt = ST_IDLE;
        end else if (full_tick) begin
          state_nxt = rx_s ? ST_IDLE : ST_STOP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame-end strobes and busy flag
  always_comb begin
    byte_strobe = 1'b0;
    byte_err    = 1'b0;
    busy        = (state != ST_IDLE);
    if (state == ST_STOP && !err_wait && full_tick) begin
      byte_strobe = rx_s;
      byte_err    = ~rx_s;
    end
`ifdef UART_RX_PARITY_EN
    if (state == ST_PARITY && full_tick && (rx_s != ^shift)) byte_err = 1'b1;
`endif
  end

  // Bit timing, data shift register and error-wait flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      err_wait <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  cnt <= '0;
        ST_START: cnt <= half_tick ? '0 : cnt + CW'(1);
        default:  cnt <= full_tick ? '0 : cnt + CW'(1);
      endcase
      if (state == ST_IDLE) bit_idx <= '0;
      else if (state == ST_DATA && full_tick) bit_idx <= bit_idx + 3'd1;
      if (state == ST_DATA && full_tick) shift <= {rx_s, shift[7:1]};
      if (byte_err) err_wait <= 1'b1;
      else if (state_nxt == ST_IDLE) err_wait <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_packet.sv
// UART packet receiver: assembles PKT_BYTES frames into byte0..byte4.
// Build option: UART_RX_PARITY_EN (even parity per frame, errors reported on frame_err).
// Partial packets live in staging registers; outputs only change on a complete packet.
module uart_rx_packet
  import uart_rx_packet_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PKT_BYTES    = DEF_PKT_BYTES,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic            clk_19k2,
  input  logic            rst,
  uart_rx_packet_if.slave bus
);
  localparam int            TO_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW     = $clog2(TO_LIM);
  localparam logic [2:0]    LAST   = 3'(PKT_BYTES - 1);
  localparam logic [TW-1:0] TO_M1  = TW'(TO_LIM - 1);

  logic [7:0]                  byte_data;
  logic                        byte_strobe, byte_err, busy;
  logic [2:0]                  idx;
  logic [TW-1:0]               idle_cnt;
  logic                        tmo;
  logic [PKT_BYTES-1:0][7:0]   stage, pkt;
  logic                        packet_valid, frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk         (clk_19k2),
    .rst         (rst),
    .rx          (bus.uart_in),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .byte_err    (byte_err),
    .busy        (busy)
  );

  // Idle timer only matters between bytes of a partial packet; a start edge
  // in the expiry cycle is still seen as IDLE here, so the timeout wins.
  assign tmo = !busy && (idx != 3'd0) && (idle_cnt == TO_M1);

  // Byte index, staging, inter-byte timeout and packet output registers
  always_ff @(posedge clk_19k2) begin
    if (rst) begin
      idx          <= '0;
      idle_cnt     <= '0;
      stage        <= '0;
      pkt          <= '0;
      packet_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_err    <= byte_err;
      if (busy || idx == 3'd0 || tmo) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + TW'(1);
      if (byte_err) begin
        idx <= '0;
      end else if (byte_strobe) begin
        stage[idx] <= byte_data;
        if (idx == LAST) begin
          idx          <= '0;
          packet_valid <= 1'b1;
          for (int i = 0; i < PKT_BYTES; i++)
            pkt[i] <= (3'(i) == idx) ? byte_data : stage[i];
        end else begin
          idx <= idx + 3'd1;
        end
      end else if (tmo) begin
        idx <= '0;
      end
    end
  end

  assign bus.byte0        = pkt[0];
  assign bus.byte1        = pkt[1];
  assign bus.byte2        = pkt[2];
  assign bus.byte3        = pkt[3];
  assign bus.byte4        = pkt[4];
  assign bus.packet_valid = packet_valid;
  assign bus.frame_err    = frame_err;

endmodule

// File: tb/tb_uart_rx_packet.sv
// Self-checking bench for uart_rx_packet: vector table, directed corner cases,
// and random byte streams scored against a packet-level model.
module tb_uart_rx_packet;
  localparam int CPB     = 16;
  localparam int TO_BITS = 10;

  logic clk_19k2 = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_19k2 = ~clk_19k2;

  uart_rx_packet_if bus();

  uart_rx_packet #(.CLKS_PER_BIT(CPB), .PKT_BYTES(5), .TIMEOUT_BITS(TO_BITS)) dut (
    .clk_19k2 (clk_19k2),
    .rst      (rst),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  int n_pv = 0, n_fe = 0, n_both = 0, n_wide = 0;
  logic prev_pv = 1'b0;
  logic [39:0] outs;
  logic [39:0] rx_pkts[$];

  assign outs = {bus.byte0, bus.byte1, bus.byte2, bus.byte3, bus.byte4};

  // Strobe monitor, sampled away from the active edge
  always @(negedge clk_19k2) begin
    if (bus.packet_valid) begin
      n_pv++;
      rx_pkts.push_back(outs);
    end
    if (bus.frame_err) n_fe++;
    if (bus.packet_valid && bus.frame_err) n_both++;
    if (bus.packet_valid && prev_pv) n_wide++;
    prev_pv = bus.packet_valid;
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    bus.uart_in = v;
    repeat (CPB) @(negedge clk_19k2);
  endtask

  task automatic idle(input int nbits);
    bus.uart_in = 1'b1;
    repeat (nbits * CPB) @(negedge clk_19k2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`else
    if (par_flip) bus.uart_in = 1'b1;
`endif
    send_bit(stop_bit);
  endtask

  task automatic send_pkt(input logic [39:0] d, input int bad_stop);
    for (int i = 0; i < 5; i++) send_byte(d[39-8*i -: 8], (i != bad_stop), 1'b0);
  endtask

  typedef struct {
    logic [39:0] data;
    int          bad_stop;
    logic [39:0] exp_out;
    int          exp_pv;
    int          exp_fe;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int pv0, fe0;
    int model_idx;
    logic [7:0] mstage[5];
    logic [7:0] b;
    logic [39:0] exp_q[$];
    bit long_gap;

    vecs[0] = '{40'h8141211109, -1, 40'h8141211109, 1, 0};
    vecs[1] = '{40'h00FF00FF5A, -1, 40'h00FF00FF5A, 1, 0};
    vecs[2] = '{40'h8141211109,  2, 40'h00FF00FF5A, 0, 1};
    vecs[3] = '{40'hA1A2A3A4A5, -1, 40'hA1A2A3A4A5, 1, 0};

    bus.uart_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk_19k2);
    chk("reset outputs", outs, 40'h0);
    chk("reset packet_valid", 40'(bus.packet_valid), 40'h0);
    chk("reset frame_err", 40'(bus.frame_err), 40'h0);
    rst = 1'b0;
    idle(2);

    // Table-driven packets (clean, all-0/all-1 data, bad stop bit on byte2)
    foreach (vecs[v]) begin
      pv0 = n_pv; fe0 = n_fe;
      send_pkt(vecs[v].data, vecs[v].bad_stop);
      idle(12);
      chk($sformatf("vec%0d packet_valid count", v), 40'(n_pv - pv0), 40'(vecs[v].exp_pv));
`ifdef UART_RX_PARITY_EN
      chk($sformatf("vec%0d frame_err seen", v), 40'(n_fe != fe0), 40'(vecs[v].exp_fe != 0));
`else
      chk($sformatf("vec%0d frame_err count", v), 40'(n_fe - fe0), 40'(vecs[v].exp_fe));
`endif
      chk($sformatf("vec%0d outputs", v), outs, vecs[v].exp_out);
    end

    // Short low glitch while idle: nothing captured, index stays 0
    pv0 = n_pv; fe0 = n_fe;
    bus.uart_in = 1'b0;
    repeat (3) @(negedge clk_19k2);
    idle(4);
    chk("glitch strobes", 40'((n_pv - pv0) + (n_fe - fe0)), 40'h0);
    send_pkt(40'h1112131415, -1);
    idle(2);
    chk("post-glitch packet count", 40'(n_pv - pv0), 40'h1);
    chk("post-glitch outputs", outs, 40'h1112131415);

    // Partial packet dropped by inter-byte timeout
    pv0 = n_pv;
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    idle(12);
    send_pkt(40'h0102030405, -1);
    idle(2);
    chk("timeout packet count", 40'(n_pv - pv0), 40'h1);
    chk("timeout outputs", outs, 40'h0102030405);

    // Reset in the middle of byte3
    pv0 = n_pv; fe0 = n_fe;
    send_byte(8'hC1, 1'b1, 1'b0);
    send_byte(8'hC2, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    bus.uart_in = 1'b1;
    @(negedge clk_19k2);
    chk("mid-frame reset outputs", outs, 40'h0);
    chk("reset-cycle strobes", 40'({bus.packet_valid, bus.frame_err}), 40'h0);
    rst = 1'b0;
    idle(12);
    chk("reset no strobes", 40'((n_pv - pv0) + (n_fe - fe0)), 40'h0);
    send_pkt(40'hF0F1F2F3F4, -1);
    idle(2);
    chk("post-reset packet count", 40'(n_pv - pv0), 40'h1);
    chk("post-reset outputs", outs, 40'hF0F1F2F3F4);

`ifdef UART_RX_PARITY_EN
    // Bad parity on byte0 drops the packet, good parity is accepted
    pv0 = n_pv; fe0 = n_fe;
    send_byte(8'h81, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) send_byte(8'(i), 1'b1, 1'b0);
    idle(12);
    chk("parity frame_err count", 40'(n_fe - fe0), 40'h1);
    chk("parity dropped packet", 40'(n_pv - pv0), 40'h0);
    send_pkt(40'h8101020304, -1);
    idle(2);
    chk("parity good packet", outs, 40'h8101020304);
`endif

    // Random byte stream with random gaps, scored against a packet model
    idle(12);
    rx_pkts.delete();
    fe0 = n_fe;
    model_idx = 0;
    for (int n = 0; n < 40; n++) begin
      long_gap = ($urandom_range(0, 7) == 0);
      idle(long_gap ? 12 : int'($urandom_range(0, 2)));
      if (long_gap) model_idx = 0;
      b = 8'($urandom);
      send_byte(b, 1'b1, 1'b0);
      mstage[model_idx] = b;
      if (model_idx == 4) begin
        exp_q.push_back({mstage[0], mstage[1], mstage[2], mstage[3], mstage[4]});
        model_idx = 0;
      end else begin
        model_idx++;
      end
    end
    idle(12);
    chk("random packet count", 40'(rx_pkts.size()), 40'(exp_q.size()));
    chk("random frame_err count", 40'(n_fe - fe0), 40'h0);
    for (int i = 0; i < exp_q.size() && i < rx_pkts.size(); i++)
      chk($sformatf("random packet %0d", i), rx_pkts[i], exp_q[i]);

    chk("valid and err together", 40'(n_both), 40'h0);
    chk("packet_valid wider than 1 cycle", 40'(n_wide), 40'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
